// File: rtl/handshake_ctrl_pkg.sv
// Shared types for the 4-phase bundled-data stage controller.
// FSM encoding, registered control bundle and watchdog sizing.
package handshake_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LAUNCH,
    ST_PRESENT,
    ST_RETURN
  } state_t;

  typedef struct packed {
    logic ack_in;
    logic dly_req;
    logic dly_en;
    logic req_out;
    logic err;
    logic busy;
  } ctl_t;

  localparam ctl_t CTL_RST = '{
    ack_in:  1'b0,
    dly_req: 1'b0,
    dly_en:  1'b0,
    req_out: 1'b0,
    err:     1'b0,
    busy:    1'b1
  };

  function automatic int wd_width(
    input int timeout
  );
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/handshake_ctrl_sync_bit.sv
// Flop-chain synchronizer for one asynchronous control bit.
// Clears to 0 on reset so stale levels never leak into the FSM.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/handshake_ctrl.sv
// Clocked 4-phase bundled-data stage controller in front of a delay line.
// FSM, watchdog, data latch and completed-transfer counter.
module handshake_ctrl
  import handshake_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_in,
  output logic             dly_req,
  output logic             dly_en,
  input  logic             dly_done,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_out,
  input  logic             err_clr,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int TW = wd_width(TIMEOUT);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic req_s;
  logic ack_s;
  logic done_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .reset (reset),
    .d     (req_in),
    .q     (req_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk   (clk),
    .reset (reset),
    .d     (ack_out),
    .q     (ack_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_done (
    .clk   (clk),
    .reset (reset),
    .d     (dly_done),
    .q     (done_s)
  );

  state_t state_q, state_d;
  ctl_t ctl_q, ctl_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load;
  logic abort;
  logic wd_hit;

  assign wd_hit = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    ctl_d = ctl_q;
    ctl_d.err = ctl_q.err & ~err_clr;
    wd_d = '0;
    cnt_d = cnt_q;
    load = 1'b0;
    abort = 1'b0;
    unique case (state_q)
      ST_FLUSH: begin
        ctl_d.dly_req = 1'b0;
        ctl_d.dly_en = 1'b0;
        if (!done_s) begin
          ctl_d.dly_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req_s) begin
          load = 1'b1;
          ctl_d.dly_req = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (done_s) begin
          ctl_d.ack_in = 1'b1;
          ctl_d.req_out = 1'b1;
          state_d = ST_PRESENT;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_PRESENT: begin
        if (ack_s && !req_s) begin
          ctl_d.ack_in = 1'b0;
          ctl_d.req_out = 1'b0;
          ctl_d.dly_req = 1'b0;
          cnt_d = cnt_q + CNT_ONE;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (!done_s && !ack_s) begin
          state_d = ST_IDLE;
        end else if (wd_hit) begin
          abort = 1'b1;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      default: begin
        ctl_d.ack_in = 1'b0;
        ctl_d.req_out = 1'b0;
        ctl_d.dly_req = 1'b0;
        ctl_d.dly_en = 1'b0;
        state_d = ST_FLUSH;
      end
    endcase
    // Timeout drops the transfer and kills the delay line
    if (abort) begin
      ctl_d.ack_in = 1'b0;
      ctl_d.req_out = 1'b0;
      ctl_d.dly_req = 1'b0;
      ctl_d.dly_en = 1'b0;
      ctl_d.err = 1'b1;
      state_d = ST_FLUSH;
    end
    ctl_d.busy = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FLUSH;
      ctl_q <= CTL_RST;
      wd_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q <= ctl_d;
      wd_q <= wd_d;
      cnt_q <= cnt_d;
      if (load) begin
        data_q <= data_in;
      end
    end
  end

  assign ack_in = ctl_q.ack_in;
  assign dly_req = ctl_q.dly_req;
  assign dly_en = ctl_q.dly_en;
  assign req_out = ctl_q.req_out;
  assign err = ctl_q.err;
  assign busy = ctl_q.busy;
  assign data_out = data_q;
  assign xfer_count = cnt_q;

endmodule
